// File: rtl/miner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : miner_pkg
// Description : Shared widths, FSM state and result record for the job
//               scheduler and its result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package miner_pkg;

    localparam int JOB_W      = 352;
    localparam int WORD_W     = 32;
    localparam int LOAD_WORDS = 11;
    localparam int ID_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    typedef struct packed {
        logic              timeout;
        logic [ID_W-1:0]   id;
        logic [WORD_W-1:0] nonce;
    } result_t;

    // Word k of a job, MSB word first.
    function automatic logic [WORD_W-1:0] job_word(input logic [JOB_W-1:0] job,
                                                   input logic [3:0]       k);
        return job[JOB_W-1-WORD_W*int'(k) -: WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/miner_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : miner_result_fifo
// Description : Small synchronous first-word-fall-through FIFO for results.
// Revision    : 1.0 - initial release
// ============================================================================
module miner_result_fifo #(
    parameter int WIDTH      = 41,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             osc_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0]  r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_do_push = push && (!full || w_do_pop);

    // Empty FIFO presents zeros so the result outputs idle at their reset values.
    assign dout = empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge osc_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/miner_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : miner_job_scheduler
// Description : Feeds jobs serially into one hashing core, supervises the scan
//               and queues one result (hit or timeout) per job.
// Revision    : 1.0 - initial release
// ============================================================================
module miner_job_scheduler
    import miner_pkg::*;
#(
    parameter logic [31:0] NONCE_OFFSET   = 32'd131,
    parameter logic [31:0] RUN_CYCLES     = 32'hFFFF_FFF0,
    parameter int          RES_DEPTH_LOG2 = 2
) (
    input  logic              osc_clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [JOB_W-1:0]  job_data,
    input  logic [ID_W-1:0]   job_id,
    input  logic              abort,
    output logic              miner_ready,
    output logic [WORD_W-1:0] miner_serial_in,
    input  logic              miner_hit,
    input  logic [WORD_W-1:0] miner_nonce,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD_W-1:0] res_nonce,
    output logic [ID_W-1:0]   res_job_id,
    output logic              res_timeout,
    output logic              busy
);

    localparam logic [3:0] C_LAST_IDX = 4'(LOAD_WORDS);

    state_t             r_state;
    logic               r_slot_full;
    logic [JOB_W-1:0]   r_slot_data;
    logic [ID_W-1:0]    r_slot_id;
    logic [JOB_W-1:0]   r_active_data;
    logic [ID_W-1:0]    r_active_id;
    logic [3:0]         r_word_idx;
    logic [31:0]        r_run_cnt;
    result_t            r_res;
    logic               r_miner_ready;
    logic [WORD_W-1:0]  r_serial;
    logic               w_slot_take;
    logic               w_push;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    result_t            w_head;

    assign job_ready       = !r_slot_full;
    assign w_slot_take     = (r_state == ST_IDLE) && r_slot_full;
    assign w_push          = (r_state == ST_REPORT) && !w_fifo_full;
    assign miner_ready     = r_miner_ready;
    assign miner_serial_in = r_serial;
    assign busy            = (r_state != ST_IDLE);

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_full <= 1'b0;
            r_slot_data <= '0;
            r_slot_id   <= '0;
        end else if (w_slot_take) begin
            r_slot_full <= 1'b0;
        end else if (job_valid && !r_slot_full) begin
            r_slot_full <= 1'b1;
            r_slot_data <= job_data;
            r_slot_id   <= job_id;
        end
    end

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_active_data <= '0;
            r_active_id   <= '0;
            r_word_idx    <= '0;
            r_run_cnt     <= '0;
            r_res         <= '0;
            r_miner_ready <= 1'b0;
            r_serial      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_slot_full) begin
                        r_active_data <= r_slot_data;
                        r_active_id   <= r_slot_id;
                        r_serial      <= job_word(r_slot_data, 4'd0);
                        r_miner_ready <= 1'b1;
                        r_word_idx    <= 4'd1;
                        r_state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_miner_ready <= 1'b0;
                        r_serial      <= '0;
                        r_state       <= ST_IDLE;
                    end else if (r_word_idx == C_LAST_IDX) begin
                        r_miner_ready <= 1'b0;
                        r_serial      <= '0;
                        r_run_cnt     <= '0;
                        r_state       <= ST_RUN;
                    end else begin
                        r_serial   <= job_word(r_active_data, r_word_idx);
                        r_word_idx <= r_word_idx + 4'd1;
                    end
                end
                ST_RUN: begin
                    r_run_cnt <= r_run_cnt + 32'd1;
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (miner_hit) begin
                        r_res   <= '{timeout: 1'b0, id: r_active_id,
                                     nonce: miner_nonce - NONCE_OFFSET};
                        r_state <= ST_REPORT;
                    end else if (r_run_cnt == RUN_CYCLES - 32'd1) begin
                        r_res   <= '{timeout: 1'b1, id: r_active_id, nonce: '0};
                        r_state <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    // Hold the captured result until the FIFO has room.
                    if (!w_fifo_full) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    miner_result_fifo #(
        .WIDTH      ($bits(result_t)),
        .DEPTH_LOG2 (RES_DEPTH_LOG2)
    ) u_result_fifo (
        .osc_clk (osc_clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .din     (r_res),
        .pop     (res_ready),
        .dout    (w_head),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    assign res_valid   = !w_fifo_empty;
    assign res_nonce   = w_head.nonce;
    assign res_job_id  = w_head.id;
    assign res_timeout = w_head.timeout;

endmodule
`default_nettype wire
